plot_sink: RTL and testbench

Receiving end of the pixel-plot interface (`x`, `y`, `colour`, `plot`) that the word/shape drawers drive. It accepts plot strobes, buffers them in a small FIFO, range-checks them against the 160x120 screen and converts each one to a linear frame-memory address. Each buffered pixel is then issued as a single-beat write to the video RAM port, which can stall on `mem_busy`. It sits between the drawing datapaths and the frame buffer, decoupling drawer timing from memory contention.

---
 rtl/plot_sink.sv | 128 ++++++++++++
 tb/tb_plot_sink.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sink.sv
`default_nettype none
// -----------------------------------------------------------------------------
// plot_sink - buffers pixel plots in a FIFO and issues single-beat frame-buffer
// writes. Optional range check: PLOT_SINK_CLIP_EN.  Rev 1.0
// -----------------------------------------------------------------------------
module plot_sink #(
  parameter int FIFO_DEPTH = 8,
  parameter int COLOUR_W   = 3,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  output logic                ready,
  output logic [14:0]         mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_busy,
  output logic                overflow,
  output logic [7:0]          clipped_count,
  output logic                idle
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              ENTRY_W = 15 + COLOUR_W;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
`ifdef PLOT_SINK_CLIP_EN
  localparam bit              CLIP_EN = 1'b1;
`else
  localparam bit              CLIP_EN = 1'b0;
`endif

  logic [ENTRY_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [14:0]         addr_q, addr_d;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic                we_q, we_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          clip_q, clip_d;

  logic                accept, push, pop, out_of_range;
  logic [ENTRY_W-1:0]  head;
  logic [14:0]         head_y15, head_x15;

  // ready comes from the registered count only, so mem_busy never reaches it
  assign ready        = !reset && (count_q < DEPTH_C);
  assign accept       = plot && ready;
  assign out_of_range = ({24'd0, x} >= 32'(SCREEN_W)) || ({25'd0, y} >= 32'(SCREEN_H));
  assign push         = accept && !(CLIP_EN && out_of_range);
  assign pop          = (count_q != '0) && (!we_q || !mem_busy);

  assign head     = fifo_q[rd_ptr_q];
  assign head_y15 = {8'd0, head[ENTRY_W-1 -: 7]};
  assign head_x15 = {7'd0, head[COLOUR_W +: 8]};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    overflow_d = overflow_q || (plot && !ready);
    clip_d     = clip_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // y*160 as two shifts; the sum stays within 15 bits for any 7-bit y / 8-bit x
    if (pop) begin
      addr_d = (head_y15 << 7) + (head_y15 << 5) + head_x15;
      data_d = head[COLOUR_W-1:0];
      we_d   = 1'b1;
    end else if (we_q && !mem_busy) begin
      we_d   = 1'b0;
    end

    if (CLIP_EN && accept && out_of_range && (clip_q != 8'hFF))
      clip_d = clip_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      overflow_q <= 1'b0;
      clip_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      overflow_q <= overflow_d;
      clip_q     <= clip_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {y, x, colour};
  end

  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
  assign mem_we        = we_q;
  assign overflow      = overflow_q;
  assign clipped_count = clip_q;
  assign idle          = (count_q == '0) && !we_q;

endmodule
`default_nettype wire

// File: tb/tb_plot_sink.sv
`default_nettype none
// Testbench for plot_sink: scoreboard of expected writes fed by an occupancy
// model at acceptance time; a negedge monitor compares and pops.
module tb_plot_sink;

  localparam int DEPTH = 8;
  localparam int CW    = 3;
  localparam int SW    = 160;
  localparam int SH    = 120;
`ifdef PLOT_SINK_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          plot = 1'b0;
  logic          mem_busy = 1'b0;
  logic [7:0]    x = '0;
  logic [6:0]    y = '0;
  logic [CW-1:0] colour = '0;
  logic          ready, mem_we, overflow, idle;
  logic [14:0]   mem_addr;
  logic [CW-1:0] mem_data;
  logic [7:0]    clipped_count;

  plot_sink #(.FIFO_DEPTH(DEPTH), .COLOUR_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .ready(ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_busy(mem_busy), .overflow(overflow), .clipped_count(clipped_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_consumed = 0;

  typedef struct { int addr; int data; } exp_t;
  exp_t sb[$];

  // Reference occupancy: entries waiting in the FIFO, and whether a write is presented
  int m_cnt = 0;
  bit m_out = 1'b0;
  bit m_ovf = 1'b0;
  int m_clip = 0;
  bit m_rdy, m_ld, m_cons, m_push, m_oor;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model, evaluated at each active edge from the driven inputs
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_out = 1'b0; m_ovf = 1'b0; m_clip = 0;
      sb.delete();
    end else begin
      m_rdy  = (m_cnt < DEPTH);
      m_cons = m_out && !mem_busy;
      m_ld   = (m_cnt > 0) && (!m_out || !mem_busy);
      m_push = 1'b0;
      m_oor  = (int'(x) >= SW) || (int'(y) >= SH);
      if (plot) begin
        if (!m_rdy) m_ovf = 1'b1;
        else if (CLIP && m_oor) begin
          if (m_clip < 255) m_clip++;
        end else begin
          sb.push_back('{addr: (int'(y) * SW + int'(x)) & 32'h7FFF, data: int'(colour)});
          m_push = 1'b1;
        end
      end
      m_cnt = m_cnt + int'(m_push) - int'(m_ld);
      m_out = m_ld ? 1'b1 : (m_cons ? 1'b0 : m_out);
    end
  end

  // Monitor: every presented write must match the oldest outstanding expectation
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("ready", 32'(ready), 32'(m_cnt < DEPTH));
      chk("mem_we", 32'(mem_we), 32'(m_out));
      chk("idle", 32'(idle), 32'(m_cnt == 0 && !m_out));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("clipped_count", 32'(clipped_count), 32'(m_clip));
      if (mem_we) begin
        if (sb.size() == 0) chk("spurious_write", 32'(mem_we), 32'd0);
        else begin
          chk("wr_addr", 32'(mem_addr), 32'(sb[0].addr));
          chk("wr_data", 32'(mem_data), 32'(sb[0].data));
          if (!mem_busy) begin
            void'(sb.pop_front());
            n_consumed++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input int xi, input int yi, input int ci);
    tick();
    plot = 1'b1; x = 8'(xi); y = 7'(yi); colour = CW'(ci);
    tick();
    plot = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (idle && sb.size() == 0) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  task automatic capture(output logic [14:0] a, output logic [CW-1:0] d);
    bit got = 1'b0;
    a = '0; d = '0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (mem_we && !mem_busy) begin
        got = 1'b1; a = mem_addr; d = mem_data;
      end
    end
    chk("capture", 32'(got), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0]   ca;
    logic [CW-1:0] cd;
    int c0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready), 1);

    // Single plot: write visible the cycle after edge k+1, consumed at k+2
    tick();
    plot = 1'b1; x = 8'd10; y = 7'd10; colour = 3'd7;
    tick();
    plot = 1'b0;
    @(negedge clk); chk("single_we_k", 32'(mem_we), 0);
    @(negedge clk); chk("single_we", 32'(mem_we), 1);
    chk("single_addr", 32'(mem_addr), 1610);
    chk("single_data", 32'(mem_data), 7);
    @(negedge clk); chk("single_we_off", 32'(mem_we), 0);
    chk("single_idle", 32'(idle), 1);

    // Fill under stall: the first plot moves to the output, eight more fill the FIFO
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 8) chk("ready_before_full", 32'(ready), 1);
      if (i == 9) chk("ready_full", 32'(ready), 0);
      plot = 1'b1; x = 8'(i); y = 7'd0; colour = CW'(i); mem_busy = 1'b1;
    end
    tick();
    plot = 1'b0;
    @(negedge clk);
    chk("overflow_set", 32'(overflow), 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold_we", 32'(mem_we), 1);
      chk("stall_hold_addr", 32'(mem_addr), 0);
      @(negedge clk);
    end
    tick();
    mem_busy = 1'b0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("b2b_we", 32'(mem_we), 1);
      chk("b2b_addr", 32'(mem_addr), 32'(j));
    end
    @(negedge clk);
    chk("b2b_end", 32'(mem_we), 0);

    // Reset mid-burst with one write presented and five queued
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      tick();
      plot = 1'b1; x = 8'(20 + i); y = 7'd3; colour = CW'(i); mem_busy = 1'b1;
    end
    tick();
    plot = 1'b0;
    @(negedge clk);
    chk("pre_rst_we", 32'(mem_we), 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_we", 32'(mem_we), 0);
    chk("midrst_idle", 32'(idle), 1);
    chk("midrst_overflow", 32'(overflow), 0);
    chk("midrst_clipped", 32'(clipped_count), 0);
    chk("midrst_ready", 32'(ready), 0);
    tick();
    reset = 1'b0; mem_busy = 1'b0;
    c0 = n_consumed;
    repeat (20) @(negedge clk);
    chk("no_stale_writes", 32'(n_consumed - c0), 0);

`ifdef PLOT_SINK_CLIP_EN
    c0 = n_consumed;
    send1(160, 0, 5);
    repeat (4) @(negedge clk);
    chk("clip_count1", 32'(clipped_count), 1);
    chk("clip_no_write", 32'(n_consumed - c0), 0);
    send1(159, 119, 6);
    capture(ca, cd);
    chk("corner_addr", 32'(ca), 19199);
    chk("corner_data", 32'(cd), 6);
    for (int i = 0; i < 300; i++) begin
      tick();
      plot = 1'b1; x = 8'd200; y = 7'($urandom_range(0, 127));
      tick();
      plot = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("clip_saturate", 32'(clipped_count), 255);
`else
    send1(200, 0, 3);
    capture(ca, cd);
    chk("noclip_addr", 32'(ca), 200);
    chk("noclip_data", 32'(cd), 3);
    chk("noclip_count", 32'(clipped_count), 0);
`endif

    // Busy toggling every cycle during a four-plot burst
    wait_idle();
    c0 = n_consumed;
    for (int i = 0; i < 4; i++) begin
      tick();
      plot = 1'b1; x = 8'(40 + i); y = 7'd50; colour = CW'(i + 1); mem_busy = ~mem_busy;
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      plot = 1'b0; mem_busy = ~mem_busy;
    end
    mem_busy = 1'b0;
    wait_idle();
    chk("toggle_writes", 32'(n_consumed - c0), 4);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      tick();
      plot     = ($urandom_range(0, 99) < 60);
      mem_busy = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 3) != 0) begin
        x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(0, 119));
      end else begin
        x = 8'($urandom_range(0, 255)); y = 7'($urandom_range(0, 127));
      end
      colour = CW'($urandom_range(0, (1 << CW) - 1));
    end
    tick();
    plot = 1'b0; mem_busy = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
